// File: rtl/storage_pkg.sv
// Shared types and defaults for the two-port Wishbone storage arbiter.
package storage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [23:0] DEF_ADR_MASK  = 24'hFF_0000;
  localparam logic [47:0] DEF_BLOCK_ADR = {24'h10_0000, 24'h00_0000};

  // One Wishbone transfer request as captured from a port
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/storage_rr_arbiter.sv
// Two-way round-robin grant; history advances only when a grant is accepted.
module storage_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = port 1 won last, so the first contention goes to port 0
  logic last;

  // Favour the port that did not win last time when both ask
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of each accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= 1'b1;
    else if (accept && |req)   last <= gnt[1];
  end

endmodule

// File: rtl/storage_arbiter.sv
// Arbitrates two Wishbone classic requesters onto RAM_BLOCKS single-port SRAMs.
// Each transfer takes IDLE -> ACCESS -> RESP; SRAM pins are driven only from
// the fields latched when the grant is taken.
module storage_arbiter
  import storage_pkg::*;
#(
  parameter int                       RAM_BLOCKS = 2,
  parameter logic [RAM_BLOCKS*24-1:0] BLOCK_ADR  = DEF_BLOCK_ADR,
  parameter logic [23:0]              ADR_MASK   = DEF_ADR_MASK
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [3:0]               m0_sel_i,
  input  logic [31:0]              m0_adr_i,
  input  logic [31:0]              m0_dat_i,
  output logic                     m0_ack_o,
  output logic [31:0]              m0_dat_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [3:0]               m1_sel_i,
  input  logic [31:0]              m1_adr_i,
  input  logic [31:0]              m1_dat_i,
  output logic                     m1_ack_o,
  output logic [31:0]              m1_dat_o,
  output logic [RAM_BLOCKS-1:0]    mem_ena,
  output logic [RAM_BLOCKS-1:0]    mem_wen,
  output logic [RAM_BLOCKS*4-1:0]  mem_wen_mask,
  output logic [7:0]               mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [RAM_BLOCKS*32-1:0] mem_rdata,
  output logic                     busy_o
);

  state_t                state;
  logic                  gnt_q;   // 0 = mgmt port, 1 = user port
  wb_req_t               cur;
  logic [RAM_BLOCKS-1:0] blk_q;   // one-hot, all zero on no match

  wb_req_t [1:0]         port_req;
  logic [1:0]            vld;
  logic [1:0]            gnt;
  logic                  accept;
  wb_req_t               nxt;
  logic [RAM_BLOCKS-1:0] blk_dec;
  logic                  in_acc;
  logic                  in_resp;
  logic [31:0]           rd_word;
  logic [31:0]           resp_dat;
  logic                  unused_adr;

  assign port_req[0] = '{we: m0_we_i, sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign port_req[1] = '{we: m1_we_i, sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};
  assign vld         = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign accept      = (state == ST_IDLE) && |vld;

  storage_rr_arbiter u_arb (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .req    (vld),
    .accept (accept),
    .gnt    (gnt)
  );

  assign nxt = gnt[0] ? port_req[0] : port_req[1];

  // Block decode of the winning address; descending scan so lowest index wins
  always_comb begin
    blk_dec = '0;
    for (int i = RAM_BLOCKS - 1; i >= 0; i--) begin
      if ((nxt.adr[23:0] & ADR_MASK) == BLOCK_ADR[i*24 +: 24]) begin
        blk_dec    = '0;
        blk_dec[i] = 1'b1;
      end
    end
  end

  // Transfer FSM; requests seen outside IDLE wait for the next IDLE
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= ST_IDLE;
      gnt_q <= 1'b0;
      cur   <= '0;
      blk_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= ST_ACCESS;
          gnt_q <= gnt[1];
          cur   <= nxt;
          blk_q <= blk_dec;
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign in_acc  = (state == ST_ACCESS);
  assign in_resp = (state == ST_RESP);
  assign busy_o  = (state != ST_IDLE);

  genvar b;
  generate
    for (b = 0; b < RAM_BLOCKS; b++) begin : g_blk
      assign mem_ena[b]             = ~(in_acc & blk_q[b]);
      assign mem_wen[b]             = ~(in_acc & blk_q[b] & cur.we);
      assign mem_wen_mask[b*4 +: 4] = (in_acc & blk_q[b]) ? cur.sel : 4'h0;
    end
  endgenerate

  assign mem_addr  = cur.adr[9:2];
  assign mem_wdata = cur.dat;

  // Select the read word of the latched block; zero when nothing matched
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RAM_BLOCKS; i++)
      if (blk_q[i]) rd_word = rd_word | mem_rdata[i*32 +: 32];
  end

  assign resp_dat = (in_resp && !cur.we) ? rd_word : 32'h0;

  // Ack only if the requester is still in its cycle
  assign m0_ack_o = in_resp & ~gnt_q & m0_cyc_i;
  assign m1_ack_o = in_resp &  gnt_q & m1_cyc_i;
  assign m0_dat_o = gnt_q ? 32'h0 : resp_dat;
  assign m1_dat_o = gnt_q ? resp_dat : 32'h0;

  assign unused_adr = ^{cur.adr[31:10], cur.adr[1:0]};

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: directed vector table, corner sequences and a
// randomized run scored against a transaction-level memory/round-robin model.
module tb_storage_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cyc = '0, stb = '0, we = '0;
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [3:0]  sel [2];
  logic        ack0, ack1;
  logic [31:0] dat0, dat1;
  logic [1:0]  mem_ena, mem_wen;
  logic [7:0]  mem_wen_mask, mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        mem_clr = 1'b1;

  int n_pass = 0, n_tot = 0;
  logic [31:0] ref_mem [2][256];
  int model_last;

  always #5 clk = ~clk;

  storage_arbiter dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wd[0]), .m0_ack_o(ack0), .m0_dat_o(dat0),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wd[1]), .m1_ack_o(ack1), .m1_dat_o(dat1),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_wen_mask(mem_wen_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy_o(busy)
  );

  // Behavioural SRAM pair: registered read, byte-masked write
  logic [31:0] sram [2][256];
  always @(posedge clk) begin
    if (mem_clr) begin
      mem_rdata <= '0;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < 256; w++) sram[b][w] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) if (!mem_ena[b]) begin
        if (!mem_wen[b])
          for (int k = 0; k < 4; k++)
            if (mem_wen_mask[b*4+k]) sram[b][mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
        mem_rdata[b*32 +: 32] <= sram[b][mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int blk_of(input logic [31:0] a);
    case (a[23:16])
      8'h00:   return 0;
      8'h10:   return 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int b = blk_of(a);
    return (b < 0) ? 32'h0 : ref_mem[b][a[9:2]];
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int b = blk_of(a);
    if (b >= 0)
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[b][a[9:2]][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a; wd[p] = d; sel[p] = s;
  endtask

  task automatic drop(input int p);
    cyc[p] = 1'b0; stb[p] = 1'b0;
  endtask

  task automatic do_reset();
    cyc = '0; stb = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
  endtask

  function automatic logic get_ack(input int p);
    return p ? ack1 : ack0;
  endfunction

  function automatic logic [31:0] get_dat(input int p);
    return p ? dat1 : dat0;
  endfunction

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  ena;
    logic [1:0]  wen;
    logic [7:0]  mask;
    logic [7:0]  addr;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [10];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 256; w++) ref_mem[b][w] = '0;
    for (int p = 0; p < 2; p++) begin adr[p] = '0; wd[p] = '0; sel[p] = '0; end

    //          port w  adr            dat            sel    ena    wen    mask   addr   rdata
    vt[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 2'b10, 2'b10, 8'h0F, 8'h04, 32'h0};
    vt[1] = '{1, 1'b1, 32'h0010_0010, 32'hA5A5A5A5, 4'hF, 2'b01, 2'b01, 8'hF0, 8'h04, 32'h0};
    vt[2] = '{1, 1'b0, 32'h0010_0010, 32'h0,        4'hF, 2'b01, 2'b11, 8'hF0, 8'h04, 32'hA5A5A5A5};
    vt[3] = '{0, 1'b0, 32'h0000_0010, 32'h0,        4'hF, 2'b10, 2'b11, 8'h0F, 8'h04, 32'hDEADBEEF};
    vt[4] = '{0, 1'b0, 32'h0030_0000, 32'h0,        4'hF, 2'b11, 2'b11, 8'h00, 8'h00, 32'h0};
    vt[5] = '{0, 1'b1, 32'h0000_0014, 32'h12345678, 4'h3, 2'b10, 2'b10, 8'h03, 8'h05, 32'h0};
    vt[6] = '{1, 1'b0, 32'h0000_0014, 32'h0,        4'hF, 2'b10, 2'b11, 8'h0F, 8'h05, 32'h00005678};
    vt[7] = '{0, 1'b1, 32'hFF10_03FC, 32'hAABBCCDD, 4'h8, 2'b01, 2'b01, 8'h80, 8'hFF, 32'h0};
    vt[8] = '{1, 1'b0, 32'h0010_03FC, 32'h0,        4'hF, 2'b01, 2'b11, 8'hF0, 8'hFF, 32'hAA000000};
    vt[9] = '{0, 1'b1, 32'h0050_0008, 32'h55667788, 4'hF, 2'b11, 2'b11, 8'h00, 8'h02, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst ena", mem_ena, 2'b11);
    chk("rst wen", mem_wen, 2'b11);
    chk("rst mask", mem_wen_mask, 0);
    chk("rst ack0", ack0, 0);
    chk("rst ack1", ack1, 0);
    chk("rst dat0", dat0, 0);
    chk("rst dat1", dat1, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    #3 rst_n = 1'b1;
    tick();

    // Directed single-port transfers
    for (int i = 0; i < 10; i++) begin
      int p = vt[i].port;
      set_req(p, vt[i].w, vt[i].a, vt[i].d, vt[i].s);
      #1 chk($sformatf("vec%0d idle busy", i), busy, 0);
      tick();
      chk($sformatf("vec%0d ena", i), mem_ena, vt[i].ena);
      chk($sformatf("vec%0d wen", i), mem_wen, vt[i].wen);
      chk($sformatf("vec%0d mask", i), mem_wen_mask, vt[i].mask);
      chk($sformatf("vec%0d addr", i), mem_addr, vt[i].addr);
      chk($sformatf("vec%0d busy", i), busy, 1);
      if (vt[i].w) chk($sformatf("vec%0d wdata", i), mem_wdata, vt[i].d);
      chk($sformatf("vec%0d early ack", i), get_ack(p), 0);
      tick();
      chk($sformatf("vec%0d ack", i), get_ack(p), 1);
      chk($sformatf("vec%0d other ack", i), get_ack(1-p), 0);
      chk($sformatf("vec%0d dat", i), get_dat(p), vt[i].rd);
      chk($sformatf("vec%0d other dat", i), get_dat(1-p), 0);
      if (vt[i].w) ref_wr(vt[i].a, vt[i].d, vt[i].s);
      drop(p);
      tick();
    end

    // Continuous contention from reset: alternating grants every 3 cycles
    begin
      int g_q [$];
      int c_q [$];
      int c = 0;
      logic both = 1'b0;
      do_reset();
      set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h0010_0010, 32'h0, 4'hF);
      #1;
      while (g_q.size() < 6 && c < 40) begin
        if (ack0 && ack1) both = 1'b1;
        if (ack0 || ack1) begin
          g_q.push_back(ack1 ? 1 : 0);
          c_q.push_back(c);
          chk("rr dat", ack1 ? dat1 : dat0, exp_read(ack1 ? adr[1] : adr[0]));
        end
        if (g_q.size() < 6) begin tick(); c++; end
      end
      drop(0); drop(1);
      tick();
      chk("rr count", g_q.size(), 6);
      chk("rr both acks", both, 0);
      for (int i = 0; i < g_q.size(); i++) begin
        chk($sformatf("rr grant%0d", i), g_q[i], i % 2);
        chk($sformatf("rr cycle%0d", i), c_q[i], 2 + 3*i);
      end
    end

    // cyc dropped in ACCESS: write lands, no ack
    set_req(0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF);
    tick();
    chk("drop wen", mem_wen, 2'b10);
    drop(0);
    tick();
    chk("drop no ack", ack0, 0);
    chk("drop busy resp", busy, 1);
    ref_wr(32'h0000_0020, 32'h11223344, 4'hF);
    tick();
    chk("drop busy idle", busy, 0);
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick(); tick();
    chk("drop rb ack", ack1, 1);
    chk("drop rb dat", dat1, 32'h11223344);
    drop(1);
    tick();

    // Reset mid-ACCESS: enable released at once, write aborted, no ack
    begin
      logic stray = 1'b0;
      set_req(0, 1'b1, 32'h0000_0024, 32'hCAFEF00D, 4'hF);
      tick();
      chk("arst ena pre", mem_ena, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst ena", mem_ena, 2'b11);
      chk("arst wen", mem_wen, 2'b11);
      chk("arst mask", mem_wen_mask, 0);
      chk("arst busy", busy, 0);
      chk("arst ack", ack0, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      drop(0);
      for (int k = 0; k < 4; k++) begin
        tick();
        if (ack0 || ack1) stray = 1'b1;
      end
      chk("arst no ack", stray, 0);
      set_req(0, 1'b0, 32'h0000_0024, 32'h0, 4'hF);
      tick(); tick();
      chk("arst rb ack", ack0, 1);
      chk("arst rb dat", dat0, exp_read(32'h0000_0024));
      drop(0);
      tick();
    end

    // Randomized traffic against the transaction model
    begin
      logic [1:0] pend = '0;
      do_reset();
      model_last = 1;
      for (int t = 0; t < 60; t++) begin
        int g, k;
        logic got;
        for (int p = 0; p < 2; p++)
          if (!pend[p] && $urandom_range(0, 1) == 1) pend[p] = 1'b1;
        if (pend == 2'b00) pend[$urandom_range(0, 1)] = 1'b1;
        for (int p = 0; p < 2; p++) if (pend[p] && !cyc[p]) begin
          int r = $urandom_range(0, 4);
          logic [31:0] a;
          a = {8'($urandom), 24'h0} | (32'($urandom_range(0, 7)) << 2);
          if (r >= 2 && r <= 3) a[23:16] = 8'h10;
          else if (r == 4)      a[23:16] = 8'h30;
          set_req(p, 1'($urandom), a, $urandom, 4'($urandom_range(1, 15)));
        end
        g = (pend == 2'b11) ? (model_last == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
        got = 1'b0;
        for (k = 0; k < 8 && !got; k++) begin
          tick();
          got = ack0 | ack1;
        end
        if (!got) begin
          chk("rnd timeout", 0, 1);
          break;
        end
        chk("rnd grant", ack1 ? 1 : 0, g);
        chk("rnd one ack", ack0 & ack1, 0);
        chk("rnd dat", get_dat(g), we[g] ? 32'h0 : exp_read(adr[g]));
        chk("rnd other dat", get_dat(1-g), 0);
        if (we[g]) ref_wr(adr[g], wd[g], sel[g]);
        model_last = g;
        drop(g);
        pend[g] = 1'b0;
      end
      drop(0); drop(1);
      tick(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/storage_arbiter.md
STORAGE_ARBITER -- requirements
Module: storage_arbiter

Interface
REQ-001 SHALL have parameter RAM_BLOCKS, default 2, number of RW SRAM blocks.
REQ-002 SHALL have parameter BLOCK_ADR, default {24'h10_0000, 24'h00_0000}, base address per block, block i in bits [24i+23:24i].
REQ-003 SHALL have parameter ADR_MASK, default 24'hFF_0000, block-select mask on adr[23:0].
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-006 wb_rst_n  in  1  asynchronous active-low reset.
REQ-007 mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  Wishbone classic controls, requester N in {0,1}; 0 = mgmt, 1 = user.
REQ-008 mN_sel_i  in  4  byte enables.
REQ-009 mN_adr_i, mN_dat_i  in  32 each  byte address, write data.
REQ-010 mN_ack_o  out  1  transfer acknowledge.
REQ-011 mN_dat_o  out  32  read data.
REQ-012 mem_ena  out  RAM_BLOCKS  per-block enable, active low.
REQ-013 mem_wen  out  RAM_BLOCKS  per-block write enable, active low.
REQ-014 mem_wen_mask  out  RAM_BLOCKS*4  per-block byte mask, active high.
REQ-015 mem_addr  out  8  word address; mem_wdata  out  32  write data.
REQ-016 mem_rdata  in  RAM_BLOCKS*32  read data, valid the cycle after enabled edge.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 Request valid for port N SHALL be mN_cyc_i & mN_stb_i.
REQ-019 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on any valid request; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-020 In IDLE with both valid, grant SHALL go to the port not granted last; with one valid, to that port; last_grant resets to 1 (first contention goes to port 0).
REQ-021 On IDLE->ACCESS, granted port's adr, dat, sel, we and decoded block SHALL be registered; memory outputs SHALL be driven only from these registers.
REQ-022 Block i selected when (adr[23:0] & ADR_MASK) == BLOCK_ADR[i]; lowest index wins on multiple match.
REQ-023 In ACCESS only: mem_ena low for selected block; mem_wen low for it if write; mem_wen_mask = sel for it, 0 for others; mem_addr = adr[9:2]; mem_wdata = dat.
REQ-024 Outside ACCESS: mem_ena and mem_wen all ones, mem_wen_mask zero.
REQ-025 In RESP, mN_ack_o SHALL be high one cycle for the granted port only if its cyc is still high; other port's ack low.
REQ-026 In RESP, granted port's mN_dat_o = selected block's mem_rdata word for reads, 0 for writes; dat_o of non-granted port and all dat_o outside RESP = 0.
REQ-027 Latency: request visible in IDLE at cycle 0 -> ack in cycle 2; back-to-back throughput one transfer per 3 cycles.
REQ-028 No-match address: no mem_ena asserted; ack still issued in RESP with dat_o = 0.
REQ-029 cyc dropped in ACCESS: memory access completes (write lands), no ack, return to IDLE.
REQ-030 A request present in RESP SHALL NOT be granted before the next IDLE.

Reset
REQ-031 Asserted wb_rst_n SHALL force IDLE, last_grant = 1, all acks 0, all dat_o 0, busy_o 0, mem_ena/mem_wen all ones, mask 0, registered fields 0, immediately and asynchronously.
REQ-032 Reset mid-ACCESS SHALL deassert mem_ena at once; no ack for the aborted transfer.

Structure
REQ-033 FSM state encoding, ADR_MASK and default BLOCK_ADR SHALL live in shared package storage_pkg.
REQ-034 Grant logic SHALL be sub-module storage_rr_arbiter (2-way round-robin, req[1:0] in, one-hot gnt out, update on accept).

Verification
REQ-035 Port 0 write adr 0x0000_0010, dat 0xDEADBEEF, sel 0xF -> cycle 1: mem_ena=2'b10, mem_wen=2'b10, mem_addr=0x04; cycle 2 m0_ack_o=1.
REQ-036 Port 1 read adr 0x0010_0010 after write of 0xA5A5A5A5 there -> m1_ack_o in cycle 2, m1_dat_o=0xA5A5A5A5.
REQ-037 Both ports requesting continuously from reset, 6 transfers -> grants 0,1,0,1,0,1.
REQ-038 Port 0 read adr 0x0030_0000 -> no mem_ena low, ack in cycle 2, m0_dat_o=0.
REQ-039 Port 0 write, m0_cyc_i dropped during ACCESS -> mem_wen low in ACCESS, no m0_ack_o.
REQ-040 wb_rst_n low during ACCESS -> mem_ena=2'b11 same cycle, busy_o=0, no ack after release.
